disp_trace_multi: RTL and testbench
===================================

# disp_trace_multi

Multi-channel oscilloscope trace renderer for the display pipeline; successor to the single-channel sparse sample renderer. Consumes CH channels of SIZE samples each from a valid/ready stream in the system clock domain. Maps each sample to a screen row and writes the trace pixels to the active framebuffer through the shared memory arbiter. Supports line (stepped staircase) and dot modes, per-channel colour and per-channel enable.

## Interface
- CH, 2, number of channels (≥1)
- SW, 10, sample width in bits, unsigned
- SIZE, 256, samples per channel (≥2)
- W, 320, framebuffer width in pixels
- H, 240, framebuffer height in pixels
- BASE, 0, framebuffer base address when stat=0
- SWAP, 0, framebuffer base address when stat=1
- Derived: XSTEP = (W-1)/(SIZE-1) (integer division); XW = $clog2(W); YW = $clog2(H)
- clkSYS  in  1  system clock; the block has one clock
- n_reset  in  1  asynchronous active-low reset
- start  in  1  one-cycle frame-render request; honoured only in Idle
- done  out  1  one-cycle pulse after the last pixel of the last channel is acknowledged
- stat  in  1  framebuffer select: 0 selects BASE, 1 selects SWAP
- mode  in  1  0 = line, 1 = dot; sampled on accepted start
- ch_en  in  CH  per-channel draw enable; sampled on accepted start
- colour  in  CH×16  per-channel pixel colour
- smpl_valid  in  1  sample present
- smpl_ready  out  1  block accepts sample (transfer when valid && ready)
- smpl  in  SW  sample value, channel-major order (all SIZE samples of ch0, then ch1, …)
- arb  arbiter_if  —  uses req, ack, addr, data, wr

## Operation
- States: Idle, Load, Hold, Span, Done.
- Idle: on start, latch mode and ch_en, clear ch and i (sample index), then go to Load.
- Load: smpl_ready=1. On transfer, compute y = (H-1) - ((smpl*H) >> SW). Use a full-width product and no clamp; the result is always in 0..H-1. Set x = i*XSTEP, kept as a running accumulator, never a multiply.
  - If the channel is disabled, only the index advances; no pixels are written.
  - If i==0, or mode=1 (dot): write one pixel (x, y).
  - Otherwise (line mode) go to Hold.
- Hold: write pixels (x', y_prev) for x' = x_prev+1 … x-1. Hold is skipped when XSTEP ≤ 1. Then go to Span.
- Span: write column x, rows min(y_prev,y) … max(y_prev,y) inclusive, ascending. y_prev==y gives 1 pixel.
- After a sample's pixels complete: y_prev ← y and x_prev ← x.
  - If i==SIZE-1, set i←0. Then if ch==CH-1 go to Done; otherwise ch←ch+1 and go to Load.
  - Otherwise i←i+1 and go to Load.
- Done: pulse done for one cycle, then go to Idle.
- Pixel write: arb.addr = (stat ? SWAP : BASE) | (row*W + col); arb.data = colour[ch]; arb.wr = 1 constant. stat is sampled per pixel.
- Samples beyond CH×SIZE are not accepted; smpl_ready stays 0 outside Load.

## Timing
- Reset values: done=0, smpl_ready=0, arb.req=0, arb.addr=0, arb.data=0. State is Idle, ch=0, i=0.
- Reset mid-frame: return to Idle immediately. Any partial sample or pixel is abandoned and req drops asynchronously.
- start to smpl_ready: start seen high in Idle at edge t gives smpl_ready=1 from t+1.
- Sample transfer at edge t: smpl_ready=0 from t+1, y registered at t+1, first arb.req for that sample asserted from t+2.
- addr and data are stable while req=1 and change only after ack.
- arb.req is held until ack. In the ack cycle req is sampled low for the next edge, so there is a ≥1 cycle bubble: maximum 1 pixel per 2 cycles.
- The next sample is accepted (smpl_ready=1) in the cycle after the last pixel's ack.
- done asserts one cycle after the final ack. For a frame with all channels disabled, done asserts one cycle after the last sample transfer.
- start while not Idle is ignored. start in the same cycle done is high is ignored.
- ch_en=0 for a channel: samples are consumed at 1 per cycle while smpl_valid=1.

## Test plan
- W=320, H=240, SIZE=33, CH=1, SW=10, dot mode, all samples 512 → 33 writes at x=0,9,…,288, row 119, addr=119*320+x, then done.
- Line mode, samples 0 then 1023, rest 1023 → pixel (0,239); Hold pixels (1..8, 239); Span at x=9 rows 0..239 (240 writes); then single pixels at row 0.
- CH=2, ch_en=2'b10, colour[1]=16'hF800 → no writes during ch0; ch1 writes carry data 16'hF800; done asserts once.
- Random arb.ack delays of 0–7 cycles and random smpl_valid gaps → write sequence identical to the no-stall run; addr and data never change while req is high.
- Assert n_reset mid-Span → req, ready and done are 0 immediately. After reset, start re-renders the full frame from ch0, i=0.
- stat=1, SWAP=32'h40000 → every address has base SWAP. start pulsed during rendering → no effect on the write count.

Source files
------------

// File: rtl/disp_trace_multi.sv
// Multi-channel oscilloscope trace renderer: turns channel-major sample streams
// into stepped-line or dot pixels and writes them one at a time through the arbiter.
module disp_trace_multi #(
  parameter int          CH   = 2,
  parameter int          SW   = 10,
  parameter int          SIZE = 256,
  parameter int          W    = 320,
  parameter int          H    = 240,
  parameter logic [31:0] BASE = 32'h0,
  parameter logic [31:0] SWAP = 32'h0
) (
  input  logic                clkSYS,
  input  logic                n_reset,
  input  logic                start,
  output logic                done,
  input  logic                stat,
  input  logic                mode,
  input  logic [CH-1:0]       ch_en,
  input  logic [CH-1:0][15:0] colour,
  input  logic                smpl_valid,
  output logic                smpl_ready,
  input  logic [SW-1:0]       smpl,
  output logic                arb_req,
  input  logic                arb_ack,
  output logic [31:0]         arb_addr,
  output logic [15:0]         arb_data,
  output logic                arb_wr
);

  localparam int XSTEP = (W - 1) / (SIZE - 1);
  localparam int XW    = $clog2(W);
  localparam int YW    = $clog2(H);
  localparam int IW    = $clog2(SIZE);
  localparam int CW    = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_SPAN, S_DONE} state_t;

  state_t           state_reg, state_next;
  logic             mode_reg;
  logic [CH-1:0]    en_reg;
  logic [CW-1:0]    ch_reg;
  logic [IW-1:0]    idx_reg;
  logic [XW-1:0]    x_reg, col_reg;
  logic [YW-1:0]    y_reg, yp_reg, row_reg, row_end_reg;
  logic             req_reg;
  logic [31:0]      addr_reg;
  logic [15:0]      data_reg;

  logic             xfer, pix_done, hold_last, span_last, idx_last, ch_last, ch_on, sample_end;
  logic [SW+YW-1:0] prod;
  logic [YW-1:0]    y_new, lo_x, hi_x, lo_h, hi_h;
  logic [XW-1:0]    x_new;
  logic [31:0]      pix_off;

  // H <= 2**YW, so the full product fits SW+YW bits and the shifted value is < H.
  assign prod       = (SW+YW)'(smpl) * (SW+YW)'(H);
  assign y_new      = YW'(H - 1) - YW'(prod >> SW);
  assign x_new      = (idx_reg == '0) ? '0 : x_reg + XW'(XSTEP);
  assign lo_x       = (y_reg < y_new) ? y_reg : y_new;
  assign hi_x       = (y_reg < y_new) ? y_new : y_reg;
  assign lo_h       = (yp_reg < y_reg) ? yp_reg : y_reg;
  assign hi_h       = (yp_reg < y_reg) ? y_reg : yp_reg;

  assign xfer       = (state_reg == S_LOAD) && smpl_valid;
  assign pix_done   = req_reg && arb_ack;
  assign hold_last  = (col_reg == x_reg - XW'(1));
  assign span_last  = (row_reg == row_end_reg);
  assign idx_last   = (idx_reg == IW'(SIZE - 1));
  assign ch_last    = (ch_reg == CW'(CH - 1));
  assign ch_on      = en_reg[ch_reg];
  assign sample_end = (xfer && !ch_on) || ((state_reg == S_SPAN) && pix_done && span_last);
  assign pix_off    = 32'(row_reg) * 32'(W) + 32'(col_reg);

  assign arb_req  = req_reg;
  assign arb_addr = addr_reg;
  assign arb_data = data_reg;
  assign arb_wr   = 1'b1;

  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    smpl_ready = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: if (start) state_next = S_LOAD;
      S_LOAD: begin
        smpl_ready = 1'b1;
        if (xfer) begin
          if (!ch_on) begin
            if (idx_last && ch_last) state_next = S_DONE;
          end else if (idx_reg == '0 || mode_reg) begin
            state_next = S_SPAN;
          end else if (XSTEP > 1) begin
            state_next = S_HOLD;
          end else begin
            state_next = S_SPAN;
          end
        end
      end
      S_HOLD: if (pix_done && hold_last) state_next = S_SPAN;
      S_SPAN: if (pix_done && span_last) state_next = (idx_last && ch_last) ? S_DONE : S_LOAD;
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      mode_reg    <= 1'b0;
      en_reg      <= '0;
      ch_reg      <= '0;
      idx_reg     <= '0;
      x_reg       <= '0;
      y_reg       <= '0;
      yp_reg      <= '0;
      col_reg     <= '0;
      row_reg     <= '0;
      row_end_reg <= '0;
      req_reg     <= 1'b0;
      addr_reg    <= '0;
      data_reg    <= '0;
    end else begin
      if (state_reg == S_IDLE && start) begin
        mode_reg <= mode;
        en_reg   <= ch_en;
        ch_reg   <= '0;
        idx_reg  <= '0;
      end
      // The pixel walker (col/row..row_end) is primed at transfer time for the first run.
      if (xfer) begin
        x_reg  <= x_new;
        y_reg  <= y_new;
        yp_reg <= y_reg;
        if (idx_reg == '0 || mode_reg) begin
          col_reg     <= x_new;
          row_reg     <= y_new;
          row_end_reg <= y_new;
        end else if (XSTEP > 1) begin
          col_reg     <= x_reg + XW'(1);
          row_reg     <= y_reg;
          row_end_reg <= y_reg;
        end else begin
          col_reg     <= x_new;
          row_reg     <= lo_x;
          row_end_reg <= hi_x;
        end
      end
      if (state_reg == S_HOLD && pix_done) begin
        if (hold_last) begin
          col_reg     <= x_reg;
          row_reg     <= lo_h;
          row_end_reg <= hi_h;
        end else begin
          col_reg <= col_reg + XW'(1);
        end
      end
      if (state_reg == S_SPAN && pix_done && !span_last) row_reg <= row_reg + YW'(1);
      if (sample_end) begin
        if (idx_last) begin
          idx_reg <= '0;
          if (!ch_last) ch_reg <= ch_reg + CW'(1);
        end else begin
          idx_reg <= idx_reg + IW'(1);
        end
      end
      // Address/data are captured when req rises and frozen until the ack.
      if ((state_reg == S_HOLD || state_reg == S_SPAN) && !req_reg) begin
        req_reg  <= 1'b1;
        addr_reg <= (stat ? SWAP : BASE) | pix_off;
        data_reg <= colour[ch_reg];
      end else if (pix_done) begin
        req_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_disp_trace_multi.sv
// Directed bench for disp_trace_multi: a frame-level model builds the expected
// pixel write list, and a monitor checks every arbiter write against it.
module tb_disp_trace_multi;

  localparam int          CH = 2, SW = 10, SIZE = 33, W = 320, H = 240;
  localparam logic [31:0] BASE = 32'h0, SWAP = 32'h40000;
  localparam int          TSTEP = (W - 1) / (SIZE - 1);
  localparam int          NS = CH * SIZE;

  logic clk = 0, n_reset = 0, start = 0, stat = 0, mode = 0;
  logic [1:0] ch_en = 0;
  logic [1:0][15:0] colour;
  logic smpl_valid = 0, arb_ack = 0;
  logic [9:0] smpl = 0;
  logic smpl_ready, done, arb_req, arb_wr;
  logic [31:0] arb_addr;
  logic [15:0] arb_data;

  int total = 0, bad = 0, cyc = 0;
  int feed [NS];
  int feed_idx = NS, wr_cnt = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0, ack_wait = 0;
  bit xfer_flag = 0, gap_en = 0, rand_ack = 0, held = 0;
  logic [31:0] h_addr;
  logic [15:0] h_data, last_data;
  logic [47:0] exp_q [$];
  logic [47:0] e;

  disp_trace_multi #(.CH(CH), .SW(SW), .SIZE(SIZE), .W(W), .H(H), .BASE(BASE), .SWAP(SWAP)) dut (
    .clkSYS(clk), .n_reset(n_reset), .start(start), .done(done), .stat(stat), .mode(mode),
    .ch_en(ch_en), .colour(colour), .smpl_valid(smpl_valid), .smpl_ready(smpl_ready), .smpl(smpl),
    .arb_req(arb_req), .arb_ack(arb_ack), .arb_addr(arb_addr), .arb_data(arb_data), .arb_wr(arb_wr)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic void push(input int x, input int y, input int c, input bit st);
    logic [31:0] a;
    a = (st ? SWAP : BASE) | 32'(y * W + x);
    exp_q.push_back({a, colour[c]});
  endfunction

  // Frame model: stepped staircase from the previous sample's point, or isolated dots.
  task automatic build_model(input bit md, input logic [1:0] en, input bit st);
    int xp, yp, s, x, y, lo, hi;
    exp_q.delete();
    for (int c = 0; c < CH; c++) begin
      if (!en[c]) continue;
      xp = 0; yp = 0;
      for (int i = 0; i < SIZE; i++) begin
        s = feed[c*SIZE + i];
        y = (H - 1) - (s * H) / 1024;
        x = i * TSTEP;
        if (i == 0 || md) push(x, y, c, st);
        else begin
          for (int xx = xp + 1; xx < x; xx++) push(xx, yp, c, st);
          lo = (y < yp) ? y : yp;
          hi = (y < yp) ? yp : y;
          for (int r = lo; r <= hi; r++) push(x, r, c, st);
        end
        xp = x; yp = y;
      end
    end
  endtask

  // Sample source: decides at mid-cycle, advances after a completed transfer.
  initial forever begin
    @(negedge clk);
    if (!n_reset) begin
      xfer_flag = 0; smpl_valid = 0;
    end else begin
      if (xfer_flag) feed_idx++;
      if (feed_idx < NS && !(gap_en && $urandom_range(0, 3) == 0)) begin
        smpl_valid = 1; smpl = 10'(feed[feed_idx]);
      end else smpl_valid = 0;
      xfer_flag = smpl_valid && smpl_ready;
    end
  end

  // Arbiter responder with optional random ack latency.
  initial forever begin
    @(negedge clk);
    if (n_reset && arb_req && !arb_ack) begin
      if (ack_wait == 0) arb_ack = 1; else ack_wait--;
    end else begin
      arb_ack = 0;
      ack_wait = rand_ack ? int'($urandom_range(0, 7)) : 0;
    end
  end

  // Compare process: every accepted write against the model, plus hold-stability.
  initial forever begin
    @(negedge clk); #1;
    if (!n_reset) held = 0;
    else begin
      if (held && arb_req) begin
        chk("addr_stable", arb_addr, h_addr);
        chk("data_stable", arb_data, h_data);
      end
      if (arb_req && arb_ack) begin
        wr_cnt++; last_data = arb_data;
        chk("wr_high", arb_wr, 1);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_write: addr 0x%0h data 0x%0h with no write expected", arb_addr, arb_data);
        end else begin
          e = exp_q.pop_front();
          chk("pix_addr", arb_addr, e[47:16]);
          chk("pix_data", arb_data, e[15:0]);
        end
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      held = arb_req && !arb_ack; h_addr = arb_addr; h_data = arb_data;
    end
  end

  task automatic run_frame(input string nm, input bit md, input logic [1:0] en, input bit st,
                           input bit gaps, input bit rack, input int exp_cyc,
                           input bit extra_start, input int abort_at);
    int n, k;
    bit pulsed, aborted;
    @(posedge clk); #2;
    mode = md; ch_en = en; stat = st; gap_en = gaps; rand_ack = rack;
    n = exp_q.size(); feed_idx = 0; wr_cnt = 0; done_cnt = 0; pulsed = 0; aborted = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    start_cyc = cyc;
    chk({nm, "_ready_after_start"}, smpl_ready, 1);
    for (k = 0; k < 20000 && done_cnt == 0 && !aborted; k++) begin
      @(negedge clk); #2;
      start = (extra_start && wr_cnt >= 5 && !pulsed);
      if (start) pulsed = 1;
      if (abort_at > 0 && wr_cnt >= abort_at) begin
        for (int j = 0; j < 50; j++) begin
          @(posedge clk); #2;
          if (arb_req) break;
        end
        chk({nm, "_req_before_reset"}, arb_req, 1);
        n_reset = 0; #1;
        chk({nm, "_rst_req"}, arb_req, 0);
        chk({nm, "_rst_ready"}, smpl_ready, 0);
        chk({nm, "_rst_done"}, done, 0);
        repeat (3) @(posedge clk);
        #2 n_reset = 1;
        aborted = 1;
      end
    end
    start = 0;
    if (aborted) return;
    if (done_cnt == 0) begin
      total++; bad++;
      $display("FAIL %s_timeout: done not seen, %0d writes of %0d", nm, wr_cnt, n);
    end
    repeat (4) @(negedge clk);
    #2;
    chk({nm, "_done_once"}, done_cnt, 1);
    chk({nm, "_exp_left"}, exp_q.size(), 0);
    chk({nm, "_wr_count"}, wr_cnt, n);
    chk({nm, "_consumed"}, feed_idx, NS);
    if (exp_cyc >= 0) chk({nm, "_done_latency"}, done_cyc - start_cyc, exp_cyc);
  endtask

  initial begin
    colour[0] = 16'h07E0; colour[1] = 16'hF800;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", done, 0);
    chk("rst_ready", smpl_ready, 0);
    chk("rst_req", arb_req, 0);
    chk("rst_addr", arb_addr, 0);
    chk("rst_data", arb_data, 0);
    #1 n_reset = 1;

    // Dot mode, mid-scale samples: row 119 at x = 0,9,...,288; ch1 disabled.
    for (int i = 0; i < NS; i++) feed[i] = 512;
    build_model(1, 2'b01, 0);
    chk("m_dot_n", exp_q.size(), 33);
    e = exp_q[0];  chk("m_dot_first", e[47:16], 38080);
    chk("m_dot_col", e[15:0], 16'h07E0);
    e = exp_q[32]; chk("m_dot_last", e[47:16], 38368);
    run_frame("dot", 1, 2'b01, 0, 0, 0, 132, 0, 0);

    // Line mode: 0 then full scale.
    for (int i = 0; i < NS; i++) feed[i] = (i % SIZE == 0) ? 0 : 1023;
    build_model(0, 2'b01, 0);
    chk("m_line_n", exp_q.size(), 528);
    e = exp_q[9];   chk("m_line_span_top", e[47:16], 9);
    e = exp_q[248]; chk("m_line_span_bot", e[47:16], 76489);
    e = exp_q[527]; chk("m_line_last", e[47:16], 288);
    run_frame("line", 0, 2'b01, 0, 0, 0, -1, 0, 0);

    // Only ch1 enabled: every write carries its colour.
    for (int i = 0; i < NS; i++) feed[i] = (i % SIZE) * 31;
    build_model(1, 2'b10, 0);
    chk("m_ch1_n", exp_q.size(), 33);
    run_frame("ch1", 1, 2'b10, 0, 0, 0, -1, 0, 0);
    chk("ch1_last_data", last_data, 16'hF800);

    // All channels disabled: one sample per cycle, done right after the last transfer.
    build_model(0, 2'b00, 0);
    run_frame("off", 0, 2'b00, 0, 0, 0, 66, 0, 0);

    // Random samples with stalls on both sides.
    for (int i = 0; i < NS; i++) feed[i] = int'($urandom_range(480, 560));
    build_model(0, 2'b11, 0);
    run_frame("stall", 0, 2'b11, 0, 1, 1, -1, 0, 0);

    // Reset in the middle of the tall span, then a clean re-render.
    for (int i = 0; i < NS; i++) feed[i] = (i % SIZE == 0) ? 0 : 1023;
    build_model(0, 2'b01, 0);
    run_frame("abort", 0, 2'b01, 0, 0, 0, -1, 0, 30);
    build_model(0, 2'b01, 0);
    run_frame("rerun", 0, 2'b01, 0, 0, 0, -1, 0, 0);

    // Swap buffer with a stray start during rendering.
    for (int i = 0; i < NS; i++) feed[i] = int'($urandom_range(0, 1023));
    build_model(1, 2'b11, 1);
    e = exp_q[0]; chk("m_swap_base", e[47:16] & 32'hFFFC0000, 32'h40000);
    run_frame("swap", 1, 2'b11, 1, 0, 1, -1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
